// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with one outstanding transaction.
// Define ARB_RR_EN for round-robin arbitration; the default is data-first priority with fetch starvation relief.
module mem_port_arbiter #(
   parameter int unsigned WORD_SIZE  = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MAX_WAIT   = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic                  if_gnt_o,
   output logic                  if_rvalid_o,
   output logic [WORD_SIZE-1:0]  if_rdata_o,
   input  logic                  d_req_i,
   input  logic                  d_we_i,
   input  logic [ADDR_WIDTH-1:0] d_addr_i,
   input  logic [WORD_SIZE-1:0]  d_wdata_i,
   output logic                  d_gnt_o,
   output logic                  d_rvalid_o,
   output logic [WORD_SIZE-1:0]  d_rdata_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [WORD_SIZE-1:0]  mem_wdata_o,
   input  logic                  mem_rvalid_i,
   input  logic [WORD_SIZE-1:0]  mem_rdata_i
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_I = 2'd1,
      WAIT_D = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   w_fetch_wins;
   logic   w_gnt_i;
   logic   w_gnt_d;

`ifdef ARB_RR_EN
   // r_last_d = 1 when data owned the previous grant; reset value means "fetch".
   logic r_last_d;

   always_comb begin
      w_fetch_wins = if_req_i && (!d_req_i || r_last_d);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_last_d <= 1'b0;
      end else if (w_gnt_i || w_gnt_d) begin
         r_last_d <= w_gnt_d;
      end
   end
`else
   logic [3:0] r_starve;

   always_comb begin
      w_fetch_wins = if_req_i && (!d_req_i || (r_starve >= 4'(MAX_WAIT)));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_starve <= '0;
      end else if (r_state == IDLE) begin
         if (if_req_i && !w_fetch_wins) begin
            r_starve <= (r_starve == 4'hF) ? r_starve : r_starve + 4'd1;
         end else begin
            r_starve <= '0;
         end
      end
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Every output is qualified by rst_ni so the port is silent while reset is held.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_i     = 1'b0;
      w_gnt_d     = 1'b0;
      if_rvalid_o = 1'b0;
      d_rvalid_o  = 1'b0;
      case (r_state)
         IDLE: begin
            w_gnt_i = rst_ni && w_fetch_wins;
            w_gnt_d = rst_ni && d_req_i && !w_fetch_wins;
            if (w_gnt_i) begin
               w_state_nxt = WAIT_I;
            end else if (w_gnt_d) begin
               w_state_nxt = WAIT_D;
            end
         end
         WAIT_I: begin
            if (mem_rvalid_i) begin
               if_rvalid_o = rst_ni;
               w_state_nxt = IDLE;
            end
         end
         WAIT_D: begin
            if (mem_rvalid_i) begin
               d_rvalid_o  = rst_ni;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      if_gnt_o    = w_gnt_i;
      d_gnt_o     = w_gnt_d;
      mem_req_o   = w_gnt_i || w_gnt_d;
      mem_we_o    = w_gnt_d && d_we_i;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (w_gnt_d) begin
         mem_addr_o  = d_addr_i;
         mem_wdata_o = d_wdata_i;
      end else if (w_gnt_i) begin
         mem_addr_o  = if_addr_i;
      end
      if_rdata_o = rst_ni ? mem_rdata_i : '0;
      d_rdata_o  = rst_ni ? mem_rdata_i : '0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: reference arbitration model, memory model, and response monitor.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int MW = 4;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = '0;
   logic        if_gnt_o, if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        d_req_i = 1'b0;
   logic        d_we_i = 1'b0;
   logic [31:0] d_addr_i = '0;
   logic [31:0] d_wdata_i = '0;
   logic        d_gnt_o, d_rvalid_o;
   logic [31:0] d_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   mem_port_arbiter #(
      .WORD_SIZE (32),
      .ADDR_WIDTH(32),
      .MAX_WAIT  (MW)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_gnt_o    (if_gnt_o),
      .if_rvalid_o (if_rvalid_o),
      .if_rdata_o  (if_rdata_o),
      .d_req_i     (d_req_i),
      .d_we_i      (d_we_i),
      .d_addr_i    (d_addr_i),
      .d_wdata_i   (d_wdata_i),
      .d_gnt_o     (d_gnt_o),
      .d_rvalid_o  (d_rvalid_o),
      .d_rdata_o   (d_rdata_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit          is_d;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] ref_mem[64];
   logic [31:0] env_mem[64];

   // Reference model: transaction in flight, remaining latency, fetch losses, last owner.
   bit          m_busy = 0;
   int          m_lat = 0;
   logic [31:0] m_resp = '0;
   int          m_losses = 0;
   bit          m_last_d = 0;

   bit          p_ireq = 0, p_dreq = 0, p_dwe = 0, p_stray = 0;
   logic [31:0] p_iaddr = '0, p_daddr = '0, p_dwdata = '0;
   int          lat_fixed = 1;
   int          mode = 0;      // 0 directed, 1 random, 2 both requesters always on
   string       gseq = "";

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic chk_str(string name, string act, string exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %s, expected %s", name, act, exp);
   endtask

   always @(negedge clk_i) begin
      if (if_rvalid_o || d_rvalid_o) begin
         if (sb.size() == 0) begin
            chk("spurious_rvalid", {30'b0, if_rvalid_o, d_rvalid_o}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("rvalid_owner", {30'b0, if_rvalid_o, d_rvalid_o}, mon_e.is_d ? 32'd1 : 32'd2);
            chk(mon_e.is_d ? "d_rdata" : "if_rdata", mon_e.is_d ? d_rdata_o : if_rdata_o, mon_e.data);
         end
      end
   end

   task automatic tick();
      bit          can_grant, fw, egi, egd;
      logic [31:0] a;
      exp_t        e;
      @(posedge clk_i); #1;
      can_grant    = !m_busy;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
      if (m_busy) begin
         m_lat--;
         if (m_lat == 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = m_resp;
            m_busy       = 0;
         end
      end else if (p_stray || (mode == 1 && $urandom_range(0, 5) == 0)) begin
         mem_rvalid_i = 1'b1;
      end
      p_stray = 0;
      if (mode != 0) begin
         if (!p_ireq && (mode == 2 || $urandom_range(0, 2) == 0)) begin
            p_ireq  = 1;
            p_iaddr = $urandom & 32'h0000_00FC;
         end
         if (!p_dreq && (mode == 2 || $urandom_range(0, 2) == 0)) begin
            p_dreq   = 1;
            p_dwe    = 1'($urandom);
            p_daddr  = $urandom & 32'h0000_00FC;
            p_dwdata = $urandom;
         end
      end
      if_req_i  = p_ireq;
      if_addr_i = p_iaddr;
      d_req_i   = p_dreq;
      d_we_i    = p_dwe;
      d_addr_i  = p_daddr;
      d_wdata_i = p_dwdata;

      @(negedge clk_i);
      egi = 0;
      egd = 0;
      if (can_grant) begin
`ifdef ARB_RR_EN
         fw = p_ireq && (!p_dreq || m_last_d);
`else
         fw = p_ireq && (!p_dreq || m_losses >= MW);
`endif
         egi = fw;
         egd = p_dreq && !fw;
         if (p_ireq && !fw) begin
            if (m_losses < 15) m_losses++;
         end else begin
            m_losses = 0;
         end
         if (egi || egd) m_last_d = egd;
      end
      chk("if_gnt", {31'b0, if_gnt_o}, {31'b0, egi});
      chk("d_gnt", {31'b0, d_gnt_o}, {31'b0, egd});
      chk("mem_req", {31'b0, mem_req_o}, {31'b0, egi | egd});
      if (egi) begin
         chk("mem_addr_fetch", mem_addr_o, p_iaddr);
         chk("mem_we_fetch", {31'b0, mem_we_o}, 32'd0);
      end else if (egd) begin
         chk("mem_addr_data", mem_addr_o, p_daddr);
         chk("mem_we_data", {31'b0, mem_we_o}, {31'b0, p_dwe});
         if (p_dwe) chk("mem_wdata", mem_wdata_o, p_dwdata);
      end else begin
         chk("mem_idle_zero", {31'b0, |{mem_we_o, mem_addr_o, mem_wdata_o}}, 32'd0);
      end
      if (if_gnt_o) gseq = {gseq, "I"};
      else if (d_gnt_o) gseq = {gseq, "D"};

      if (egi || egd) begin
         // The memory model acts on what the DUT actually puts on the bus.
         if (mem_we_o) begin
            env_mem[mem_addr_o[7:2]] = mem_wdata_o;
            m_resp = '0;
         end else begin
            m_resp = env_mem[mem_addr_o[7:2]];
         end
         e.is_d = egd;
         a = egd ? p_daddr : p_iaddr;
         if (egd && p_dwe) begin
            ref_mem[a[7:2]] = p_dwdata;
            e.data = '0;
         end else begin
            e.data = ref_mem[a[7:2]];
         end
         sb.push_back(e);
         m_busy = 1;
         m_lat  = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 3);
         if (egi) p_ireq = 0;
         else p_dreq = 0;
      end
   endtask

   task automatic apply_reset(int cycles);
      @(posedge clk_i); #1;
      rst_ni       = 1'b0;
      if_req_i     = 1'b1;
      d_req_i      = 1'b1;
      d_we_i       = 1'b1;
      if_addr_i    = '1;
      d_addr_i     = '1;
      d_wdata_i    = '1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = '1;
      sb.delete();
      m_busy   = 0;
      m_losses = 0;
      m_last_d = 0;
      p_ireq   = 0;
      p_dreq   = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk_i);
         chk("reset_outputs_zero",
             {31'b0, |{if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
                       mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}}, 32'd0);
         @(posedge clk_i); #1;
      end
      rst_ni       = 1'b1;
      if_req_i     = 1'b0;
      d_req_i      = 1'b0;
      d_we_i       = 1'b0;
      mem_rvalid_i = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         ref_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
         env_mem[i] = ref_mem[i];
      end
      ref_mem[4] = 32'hDEAD_BEEF;
      env_mem[4] = 32'hDEAD_BEEF;
      apply_reset(2);

      // Single fetch, 1-cycle memory.
      mode = 0; lat_fixed = 1;
      p_ireq = 1; p_iaddr = 32'h10;
      repeat (3) tick();

      // Data write then read back.
      p_dreq = 1; p_dwe = 1; p_daddr = 32'h20; p_dwdata = 32'h55;
      repeat (3) tick();
      p_dreq = 1; p_dwe = 0; p_daddr = 32'h20;
      repeat (3) tick();

      // Slow memory with a new data request raised during the wait.
      lat_fixed = 3;
      p_dreq = 1; p_dwe = 0; p_daddr = 32'h30;
      tick();
      p_dreq = 1; p_dwe = 1; p_daddr = 32'h34; p_dwdata = 32'h1234_5678;
      repeat (8) tick();

      // Continuous contention from a clean reset.
      apply_reset(1);
      mode = 2; lat_fixed = 1; gseq = "";
      repeat (22) tick();
`ifdef ARB_RR_EN
      chk_str("contention_seq", gseq.substr(0, 9), "DIDIDIDIDI");
`else
      chk_str("contention_seq", gseq.substr(0, 9), "DDDDIDDDDI");
`endif
      mode = 0;
      repeat (10) tick();

      // Reset while waiting on a data read, then a late response.
      lat_fixed = 6;
      p_dreq = 1; p_dwe = 0; p_daddr = 32'h40;
      repeat (2) tick();
      apply_reset(2);
      lat_fixed = 1;
      p_stray = 1;
      tick();
      p_ireq = 1; p_iaddr = 32'h44;
      repeat (3) tick();

      // Randomized traffic with variable latency and stray responses in IDLE.
      mode = 1; lat_fixed = 0;
      repeat (800) tick();
      mode = 0;
      repeat (16) tick();
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one memory port between the core's instruction-fetch requester and its load/store requester. It arbitrates, forwards the winning request to the memory, tracks the single outstanding transaction, and routes the response back to its owner. It sits between `riscv_core` and a unified memory, so instruction and data traffic can use one physical memory.

## Interface
Parameters:
- `WORD_SIZE`, 32: data width of all data buses.
- `ADDR_WIDTH`, 32: width of all address buses.
- `MAX_WAIT`, 4: consecutive lost arbitrations after which fetch is forced to win (fixed-priority mode only). Legal range 1..15.

Ports (clock and reset first):
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `if_req_i`  in  1  fetch request; held with `if_addr_i` stable until `if_gnt_o`.
- `if_addr_i`  in  ADDR_WIDTH  fetch address.
- `if_gnt_o`  out  1  fetch request accepted this cycle.
- `if_rvalid_o`  out  1  fetch response valid.
- `if_rdata_o`  out  WORD_SIZE  fetch read data.
- `d_req_i`  in  1  data request; held with its address, data and write enable stable until `d_gnt_o`.
- `d_we_i`  in  1  1 = write, 0 = read.
- `d_addr_i`  in  ADDR_WIDTH  data address.
- `d_wdata_i`  in  WORD_SIZE  write data.
- `d_gnt_o`  out  1  data request accepted this cycle.
- `d_rvalid_o`  out  1  data response valid (read data, or write acknowledge).
- `d_rdata_o`  out  WORD_SIZE  data read data.
- `mem_req_o`  out  1  memory request strobe; one cycle per transaction.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o`  out  ADDR_WIDTH  memory address.
- `mem_wdata_o`  out  WORD_SIZE  memory write data.
- `mem_rvalid_i`  in  1  memory response valid; arrives one or more cycles after `mem_req_o`.
- `mem_rdata_i`  in  WORD_SIZE  memory read data, valid with `mem_rvalid_i`.

## Operation
- FSM states: IDLE, WAIT_I, WAIT_D.
- **IDLE:**
  - Arbitrate among the active requests.
  - Drive `mem_req_o` = 1 and the winner's gnt = 1 combinationally, in the same cycle.
  - Mux the winner's address, write enable and write data onto the `mem_*` outputs.
  - Next state is WAIT_I or WAIT_D. With no request, stay in IDLE.
- **WAIT_x:**
  - `mem_req_o` = 0 and both gnt outputs = 0.
  - When `mem_rvalid_i` = 1, assert the owner's rvalid in the same cycle and return to IDLE.
- Read data: `if_rdata_o` and `d_rdata_o` both equal `mem_rdata_i`. Only the rvalid outputs are steered.
- `mem_rvalid_i` in IDLE is ignored; no rvalid is produced.
- Exactly one transaction is outstanding at any time.
- Fixed-priority arbitration (default):
  - Data beats fetch.
  - A 4-bit starvation counter increments whenever `if_req_i` = 1 and fetch loses in IDLE. It saturates at 15.
  - The counter clears when fetch is granted, or when `if_req_i` = 0 in IDLE.
  - When the counter is ≥ `MAX_WAIT`, fetch beats data.
- Unused `mem_*` outputs are 0 when `mem_req_o` = 0.
- Reset:
  - While `rst_ni` = 0, every output is forced to 0.
  - State goes to IDLE and the counter to 0.
  - Reset mid-transaction drops the pending response. A late `mem_rvalid_i` arriving in IDLE is ignored.

## Timing
- Grant in cycle N; `mem_req_o` is high only in cycle N.
- Response rvalid is in the same cycle as `mem_rvalid_i`, at the earliest N+1.
- The next grant comes at the earliest in the cycle after the response cycle.
- Peak throughput is one transaction per 2 cycles with a 1-cycle memory.
- Requests raised while in WAIT_x are held by the requester and considered in the next IDLE cycle.
- All output reset values are 0.

## Configuration
- `ARB_RR_EN` defined:
  - Round-robin arbitration. A 1-bit last-owner register is updated on every grant; on contention the requester not granted last wins.
  - The last-owner register resets to "fetch", so data wins the first contention.
  - The starvation counter and `MAX_WAIT` are unused.
- `ARB_RR_EN` undefined: fixed priority with the starvation counter, as described above.

## Test plan
- **Single fetch.**
  - Stimulus: `if_req_i` = 1, addr 0x10; memory returns 0xDEADBEEF one cycle later.
  - Required: `if_gnt_o` and `mem_req_o` high in the same cycle with `mem_addr_o` = 0x10; next cycle `if_rvalid_o` = 1 and `if_rdata_o` = 0xDEADBEEF; `d_rvalid_o` stays 0.
- **Data write.**
  - Stimulus: `d_req_i` = 1, `d_we_i` = 1, addr 0x20, wdata 0x55.
  - Required: `mem_we_o` = 1, `mem_addr_o` = 0x20, `mem_wdata_o` = 0x55; `d_rvalid_o` pulses when `mem_rvalid_i` = 1.
- **Contention, default build.**
  - Stimulus: both requesters held high continuously, `MAX_WAIT` = 4.
  - Required: grant sequence D,D,D,D,I,D,D,D,D,I.
- **Contention, `ARB_RR_EN` build.**
  - Stimulus: both requesters held high continuously.
  - Required: grant sequence D,I,D,I.
- **Slow memory.**
  - Stimulus: memory latency 3 cycles; a new `d_req_i` is raised during the wait.
  - Required: no gnt and no `mem_req_o` until the cycle after the response.
- **Reset mid-transaction.**
  - Stimulus: assert `rst_ni` = 0 in WAIT_D, release it, then pulse `mem_rvalid_i`.
  - Required: all outputs 0 during reset; no rvalid after release; the next `if_req_i` is granted immediately.
